// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: data-path and register-index
// widths, plus the write-back select encoding.
package wb_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage : wb_stage_pkg

// File: rtl/wb_mux.sv
// Combinational 2:1 selector that picks the write-back data: the ALU result or
// the memory read data, depending on the write-back select.
module wb_mux
    import wb_stage_pkg::*;
#(
    parameter int MUX_W = 32
) (
    input  logic             sel_i,
    input  logic [MUX_W-1:0] alu_i,
    input  logic [MUX_W-1:0] mem_i,
    output logic [MUX_W-1:0] y_o
);

    always_comb begin
        // NOTE: give every always_comb output a default first, so no path can infer a latch.
        y_o = alu_i;
        if (sel_i == WB_SEL_MEM) begin
            y_o = mem_i;
        end
    end

endmodule : wb_mux

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back data select driving the register-file write port.
// Optional macro WB_X0_GUARD_EN suppresses write enables aimed at register x0.
module wb_stage #(
    parameter int DATA_W     = wb_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [REG_ADDR_W-1:0] reg_rd_in,
    output logic [DATA_W-1:0]     alu_data_mem_wb,
    output logic [REG_ADDR_W-1:0] reg_rd_out,
    output logic                  reg_write_out
);

    logic                  reg_write_q,  reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0]     read_data_q,  read_data_d;
    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic [REG_ADDR_W-1:0] reg_rd_q,     reg_rd_d;

    // No stall or enable: every edge captures whatever MEM presents.
    always_comb begin
        reg_write_d  = reg_write_in;
        mem_to_reg_d = mem_to_reg_in;
        read_data_d  = read_data_in;
        alu_result_d = alu_result_in;
        reg_rd_d     = reg_rd_in;
    end

    // The data registers are cleared too, so X inputs seen during reset never reach the outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            reg_rd_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            reg_rd_q     <= reg_rd_d;
        end
    end

    wb_mux #(
        .MUX_W (DATA_W)
    ) u_wb_mux (
        .sel_i (mem_to_reg_q),
        .alu_i (alu_result_q),
        .mem_i (read_data_q),
        .y_o   (alu_data_mem_wb)
    );

    assign reg_rd_out = reg_rd_q;

`ifdef WB_X0_GUARD_EN
    assign reg_write_out = reg_write_q & (reg_rd_q != '0);
`else
    assign reg_write_out = reg_write_q;
`endif

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed steps followed by random traffic,
// compared against a transaction-level model of the write-back port.
module tb_wb_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  reg_rd_in;
    logic [31:0] alu_data_mem_wb;
    logic [4:0]  reg_rd_out;
    logic        reg_write_out;

    int   total = 0;
    int   bad   = 0;
    txn_t model;

    wb_stage dut (
        .clock           (clock),
        .reset           (reset),
        .reg_write_in    (reg_write_in),
        .mem_to_reg_in   (mem_to_reg_in),
        .read_data_in    (read_data_in),
        .alu_result_in   (alu_result_in),
        .reg_rd_in       (reg_rd_in),
        .alu_data_mem_wb (alu_data_mem_wb),
        .reg_rd_out      (reg_rd_out),
        .reg_write_out   (reg_write_out)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input txn_t t);
        reg_write_in  = t.rw;
        mem_to_reg_in = t.m2r;
        read_data_in  = t.rdata;
        alu_result_in = t.alu;
        reg_rd_in     = t.rd;
    endtask

    // The register file sees the last accepted transaction: memory data or ALU
    // result as chosen by that transaction, its rd, and its write request.
    task automatic check_port(input string tag);
        logic [31:0] exp_data;
        logic        exp_we;
        exp_data = model.m2r ? model.rdata : model.alu;
        exp_we   = model.rw;
`ifdef WB_X0_GUARD_EN
        if (model.rd == 5'd0) exp_we = 1'b0;
`endif
        check({tag, ".data"}, alu_data_mem_wb, exp_data);
        check({tag, ".rd"},   {27'd0, reg_rd_out}, {27'd0, model.rd});
        check({tag, ".we"},   {31'd0, reg_write_out}, {31'd0, exp_we});
    endtask

    // One clock edge: the model accepts whatever is on the inputs unless reset is high.
    task automatic cycle;
        @(posedge clock);
        if (reset) model = '0;
        else model = '{reg_write_in, mem_to_reg_in, read_data_in, alu_result_in, reg_rd_in};
        @(negedge clock);
    endtask

    function automatic txn_t rand_txn;
        txn_t t;
        t.rw    = 1'($urandom_range(0, 1));
        t.m2r   = 1'($urandom_range(0, 1));
        t.rdata = $urandom;
        t.alu   = $urandom;
        t.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return t;
    endfunction

    initial begin
        model = '0;
        reset = 1'b1;
        drive(rand_txn());

        // Reset held with arbitrary inputs.
        cycle();
        drive(rand_txn());
        cycle();
        check("reset_hold.data", alu_data_mem_wb, 32'h0);
        check("reset_hold.rd",   {27'd0, reg_rd_out}, 32'h0);
        check("reset_hold.we",   {31'd0, reg_write_out}, 32'h0);

        // Deassert at the falling edge; nothing is captured until the next rising edge.
        reset = 1'b0;
        drive('{1'b1, 1'b0, 32'h0, 32'hA5A5A5A5, 5'b01010});
        #1;
        check("deassert_wait.data", alu_data_mem_wb, 32'h0);
        check("deassert_wait.we",   {31'd0, reg_write_out}, 32'h0);
        #4;
        cycle();
        check_port("alu_sel");
        check("alu_sel.const", alu_data_mem_wb, 32'hA5A5A5A5);

        drive('{1'b1, 1'b1, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'b01010});
        cycle();
        check_port("mem_sel");
        check("mem_sel.const", alu_data_mem_wb, 32'h5A5A5A5A);

        drive('{1'b0, 1'b1, 32'h5A5A5A5A, 32'hA5A5A5A5, 5'b01010});
        cycle();
        check_port("no_write");
        check("no_write.const", {31'd0, reg_write_out}, 32'h0);

        // Mid-cycle input change must not show until the next rising edge.
        #2;
        drive('{1'b1, 1'b0, 32'h5A5A5A5A, 32'h12345678, 5'b01010});
        #1;
        check("latency_mid.data", alu_data_mem_wb, 32'h5A5A5A5A);
        #1;
        check("latency_late.data", alu_data_mem_wb, 32'h5A5A5A5A);
        cycle();
        check_port("latency_after");
        check("latency_after.const", alu_data_mem_wb, 32'h12345678);

        drive('{1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd0});
        cycle();
        check_port("x0_write");
        check("x0_write.const", alu_data_mem_wb, 32'hDEADBEEF);

        // Asynchronous reset between edges clears outputs immediately.
        drive('{1'b1, 1'b1, 32'hCAFEF00D, 32'h0BADC0DE, 5'd17});
        cycle();
        check_port("pre_async");
        #2;
        reset = 1'b1;
        model = '0;
        #1;
        check_port("async_reset");

        // X inputs during reset must not leak through.
        reg_write_in  = 1'bx;
        mem_to_reg_in = 1'bx;
        read_data_in  = 'x;
        alu_result_in = 'x;
        reg_rd_in     = 'x;
        #2;
        cycle();
        check_port("x_in_reset");
        reset = 1'b0;

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 60; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            drive(rand_txn());
            cycle();
            check_port($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_stage
